bcd_down_counter: RTL and testbench
===================================

// Module: bcd_down_counter
// PURPOSE
//   Synchronous multi-digit BCD down-counter with parallel load; decrement companion to the BCD up-counters.
//   Used for countdown timers and delay blocks.
//   Counts from a loaded BCD value down to zero, then wraps or reloads.
//   Provides a zero flag and a cascadable borrow output.
// PARAMETERS
//   DIGITS   2   number of BCD digits; count width = 4*DIGITS
// PORTS
//   clk        in   1           clock; all state updates on falling edge (negedge clk)
//   reset      in   1           asynchronous, active-low reset
//   load       in   1           parallel load strobe, sampled on negedge clk
//   load_val   in   4*DIGITS    BCD load value, digit 0 = bits [3:0]
//   en         in   1           count enable (decrement by 1 per enabled edge)
//   count      out  4*DIGITS    current BCD value, registered
//   zero       out  1           1 when count == 0 (combinational from count)
//   borrow     out  1           en & zero & ~load; terminal-borrow for cascading
// BEHAVIOUR
//   - Reset (reset==0, any time, asynchronous):
//     count=0, zero=1, borrow=0 (en permitting); reload register=0.
//   - Priority at each negedge clk: reset > load > en > hold.
//   - load=1: count <= load_val, with each digit >9 (10..15) forced to 9. en is ignored that edge.
//   - en=1, load=0, count!=0: decrement by one in BCD:
//     - digit 0 decrements;
//     - a digit at 0 with borrow-in becomes 9 and passes borrow to the next digit.
//     - Example: 40 -> 39, 10 -> 09.
//   - en=1, load=0, count==0: terminal event; borrow=1 during this cycle.
//     Next value depends on AUTO_RELOAD_EN (see CONFIGURATION).
//   - en=0, load=0: count holds.
//   - Latency: count reflects load/decrement one negedge after the strobe; zero/borrow follow combinationally.
//   - Digits never hold values >9 after reset or any load.
//   - Reset deasserting mid-count restarts from 0. Reset asserted between edges clears count immediately.
// CONFIGURATION
//   AUTO_RELOAD_EN undefined:
//     terminal event wraps count to all 9s (DIGITS=2: 00 -> 99).
//   AUTO_RELOAD_EN defined:
//     - An internal reload register captures the sanitised load_val on every load.
//     - The terminal event sets count <= reload register, not all 9s.
//     - If the reload register is 0, count stays 0 and borrow asserts on every enabled edge.
// STRUCTURE
//   - Shared package bcd_pkg:
//     - constants BCD_MAX = 4'd9 and BCD_ZERO = 4'd0;
//     - function bcd_sanitise(digit): returns 9 for a digit >9, else the digit.
//   - One sub-module bcd_down_digit: a single 4-bit BCD digit register.
//     - Inputs: clk, reset, load, load_digit, borrow_in.
//     - Outputs: digit, borrow_out (digit==0 & borrow_in).
//   - Top module instantiates DIGITS copies in a generate loop.
//     - borrow_in of digit 0 = en & ~load.
//     - The optional reload register and terminal mux live in the top.
// TESTING (DIGITS=2)
//   1. Reset: pulse reset low mid-cycle -> count=00 and zero=1 immediately, without waiting for a clk edge.
//   2. Load and decrement: load 8'h12, then en for 3 edges -> 11, 10, 09; zero=0 throughout.
//   3. Terminal wrap (macro off): load 8'h01, en -> 00 (zero=1); next en edge: borrow=1 before it, count -> 99.
//   4. Auto-reload (AUTO_RELOAD_EN on): load 8'h03, en for 4 edges -> 02, 01, 00, 03; borrow=1 only while count=00.
//   5. Sanitise and priority: load 8'hAF with en=1 -> count=99, no decrement on that edge; next en edge -> 98.
//   6. Hold: en=0 for 5 edges at count=57 -> count stays 57; borrow=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the BCD counter family.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Digits above 9 are clamped so that a bad load can never produce non-BCD state.
    function automatic logic [3:0] bcd_sanitise(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD digit register for the down-counter: load, decrement on borrow-in,
// wrap 0 -> 9 and pass the borrow to the next digit.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= bcd_sanitise(load_digit);
        end else if (borrow_in) begin
            digit <= (digit == BCD_ZERO) ? BCD_MAX : (digit - 4'd1);
        end
    end

    assign borrow_out = borrow_in & (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with parallel load, zero flag and cascadable borrow.
// Optional macro AUTO_RELOAD_EN: terminal count reloads the last loaded value instead of wrapping to all 9s.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  borrow
);

    logic [DIGITS:0]       borrow_chain;
    logic [4*DIGITS-1:0]   load_clean;
    logic [4*DIGITS-1:0]   digit_val;
    logic                  digit_load;

    assign borrow_chain[0] = en & ~load;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            assign load_clean[4*i +: 4] = bcd_sanitise(load_val[4*i +: 4]);

            bcd_down_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (digit_load),
                .load_digit (digit_val[4*i +: 4]),
                .borrow_in  (borrow_chain[i]),
                .digit      (count[4*i +: 4]),
                .borrow_out (borrow_chain[i+1])
            );
        end
    endgenerate

    // The borrow rippling out of the top digit is exactly en & ~load & (count == 0).
    assign zero   = (count == '0);
    assign borrow = borrow_chain[DIGITS];

`ifdef AUTO_RELOAD_EN
    logic [4*DIGITS-1:0] reload_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_clean;
        end
    end

    // Terminal event is turned into a load of the reload register; a natural
    // ripple would otherwise land on all 9s.
    assign digit_load = load | borrow_chain[DIGITS];
    assign digit_val  = load ? load_clean : reload_q;
`else
    assign digit_load = load;
    assign digit_val  = load_clean;
`endif

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench for bcd_down_counter (DIGITS=2); state changes on negedge clk.
module tb_bcd_down_counter;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic [7:0] count;
    logic       zero;
    logic       borrow;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [7:0] exp_q[$];

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .zero     (zero),
        .borrow   (borrow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Let one active (falling) edge pass, then settle just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] val, input logic e);
        load     = ld;
        load_val = val;
        en       = e;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("reset_count", count, 8'h00);
        check("reset_zero", {7'd0, zero}, 8'd1);
        check("reset_borrow", {7'd0, borrow}, 8'd0);
        reset = 1'b1;
        tick();

        // load and decrement
        drive(1'b1, 8'h12, 1'b0);
        tick();
        check("load_12", count, 8'h12);
        drive(1'b0, 8'h00, 1'b1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h09);
        while (exp_q.size() > 0) begin
            tick();
            check("dec_count", count, exp_q.pop_front());
            check("dec_zero", {7'd0, zero}, 8'd0);
        end

        // asynchronous reset between edges
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        #2;
        check("async_rst_count", count, 8'h00);
        check("async_rst_zero", {7'd0, zero}, 8'd1);
        reset = 1'b1;
        tick();
        check("after_rst_hold", count, 8'h00);

`ifndef AUTO_RELOAD_EN
        drive(1'b1, 8'h01, 1'b0);
        tick();
        check("load_01", count, 8'h01);
        drive(1'b0, 8'h00, 1'b1);
        check("borrow_at_01", {7'd0, borrow}, 8'd0);
        tick();
        check("dec_to_00", count, 8'h00);
        check("zero_at_00", {7'd0, zero}, 8'd1);
        check("borrow_at_00", {7'd0, borrow}, 8'd1);
        tick();
        check("wrap_99", count, 8'h99);
        check("borrow_after_wrap", {7'd0, borrow}, 8'd0);
`else
        drive(1'b1, 8'h03, 1'b0);
        tick();
        check("load_03", count, 8'h03);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("ar_02", count, 8'h02);
        check("ar_borrow_02", {7'd0, borrow}, 8'd0);
        tick();
        check("ar_01", count, 8'h01);
        tick();
        check("ar_00", count, 8'h00);
        check("ar_borrow_00", {7'd0, borrow}, 8'd1);
        tick();
        check("ar_reload_03", count, 8'h03);
        check("ar_borrow_03", {7'd0, borrow}, 8'd0);
        // zero reload value: stuck at 00 with borrow every enabled edge
        drive(1'b1, 8'h00, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 2; k++) begin
            check("ar0_borrow", {7'd0, borrow}, 8'd1);
            tick();
            check("ar0_count", count, 8'h00);
        end
`endif

        // load beats en, load suppresses borrow at zero, digits sanitised
        drive(1'b1, 8'h00, 1'b0);
        tick();
        check("load_00", count, 8'h00);
        drive(1'b1, 8'hAF, 1'b1);
        check("borrow_masked_by_load", {7'd0, borrow}, 8'd0);
        tick();
        check("sanitise_AF", count, 8'h99);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("dec_98", count, 8'h98);

        drive(1'b1, 8'h3A, 1'b0);
        tick();
        check("sanitise_3A", count, 8'h39);
        drive(1'b1, 8'h40, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("dec_40_39", count, 8'h39);
        drive(1'b1, 8'h10, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("dec_10_09", count, 8'h09);

        // hold
        drive(1'b1, 8'h57, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_57", count, 8'h57);
            check("hold_borrow", {7'd0, borrow}, 8'd0);
        end

        // enable off at zero: no borrow
        drive(1'b1, 8'h00, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check("idle_zero", {7'd0, zero}, 8'd1);
        check("idle_borrow", {7'd0, borrow}, 8'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
